// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: widths, bubble/HALT encodings,
// FSM state type and the rule that derives ctrlSignal from an instruction.
package fetch_stage_pkg;

   localparam int INSTR_W = 16;
   localparam int CTRL_W  = 8;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'hE000;
   localparam logic [CTRL_W-1:0]  HALT_CTRL = 8'hF0;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   // Control decoder sees the opcode nibble and the function nibble only.
   function automatic logic [CTRL_W-1:0] ctrl_of(input logic [INSTR_W-1:0] instr);
      return {instr[INSTR_W-1 -: 4], instr[3:0]};
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: carries the fetched instruction, its PC+2, the
// pre-extracted control field and a valid flag into decode.
module if_id_reg #(
   parameter logic [15:0] NOP_INSTR = 16'hE000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        flush,
   input  logic        hold,
   input  logic [15:0] instrIn,
   input  logic [15:0] pcPlus2In,
   output logic [15:0] instrOut,
   output logic [15:0] pcPlus2Out,
   output logic [7:0]  ctrlSignal,
   output logic        validOut
);
   import fetch_stage_pkg::*;

   // Flush beats hold so a redirect can squash a stalled slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instrOut   <= NOP_INSTR;
         pcPlus2Out <= '0;
         ctrlSignal <= ctrl_of(NOP_INSTR);
         validOut   <= 1'b0;
      end else if (flush) begin
         instrOut   <= NOP_INSTR;
         pcPlus2Out <= '0;
         ctrlSignal <= ctrl_of(NOP_INSTR);
         validOut   <= 1'b0;
      end else if (hold) begin
         instrOut   <= instrOut;
         pcPlus2Out <= pcPlus2Out;
         ctrlSignal <= ctrlSignal;
         validOut   <= validOut;
      end else if (load) begin
         instrOut   <= instrIn;
         pcPlus2Out <= pcPlus2In;
         ctrlSignal <= ctrl_of(instrIn);
         validOut   <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and the RUN/HALTED FSM, drives instruction
// memory and feeds the IF/ID register.
module fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirectTarget,
   input  logic [15:0] instrIn,
   output logic [15:0] instrAddr,
   output logic [15:0] instrOut,
   output logic [15:0] pcPlus2Out,
   output logic [7:0]  ctrlSignal,
   output logic        validOut,
   output logic        halted
);
   import fetch_stage_pkg::*;

   fetch_state_t state;
   logic [15:0]  pc;
   logic [15:0]  pc_plus2;
   logic         is_halt;
   logic         reg_load;
   logic         reg_flush;
   logic         reg_hold;

   assign instrAddr = pc;
   assign pc_plus2  = pc + 16'd2;
   assign is_halt   = (ctrl_of(instrIn) == HALT_CTRL);

   // Edge priority: redirect, then HALTED bubble, then stall, then fetch.
   assign reg_flush = redirect || (state == HALTED);
   assign reg_hold  = !reg_flush && stall;
   assign reg_load  = !reg_flush && !stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc     <= RESET_PC;
         state  <= RUN;
         halted <= 1'b0;
      end else if (redirect) begin
         pc     <= redirectTarget;
         state  <= RUN;
         halted <= 1'b0;
      end else if (state == HALTED) begin
         pc     <= pc;
         halted <= 1'b1;
      end else if (stall) begin
         pc <= pc;
      end else if (is_halt) begin
         // HALT enters IF/ID now; PC parks on the HALT address.
         pc     <= pc;
         state  <= HALTED;
         halted <= 1'b1;
      end else begin
         pc <= pc_plus2;
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk        (clk),
      .rst        (rst),
      .load       (reg_load),
      .flush      (reg_flush),
      .hold       (reg_hold),
      .instrIn    (instrIn),
      .pcPlus2In  (pc_plus2),
      .instrOut   (instrOut),
      .pcPlus2Out (pcPlus2Out),
      .ctrlSignal (ctrlSignal),
      .validOut   (validOut)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory:
// mem[a] = {4'h1, a[11:0]}, optionally with a HALT (16'hF000) at 0x000C.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [15:0] redirectTarget;
   logic [15:0] instrIn;
   logic [15:0] instrAddr;
   logic [15:0] instrOut;
   logic [15:0] pcPlus2Out;
   logic [7:0]  ctrlSignal;
   logic        validOut;
   logic        halted;
   logic        halt_en;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   always_comb begin
      instrIn = {4'h1, instrAddr[11:0]};
      if (halt_en && instrAddr == 16'h000C) instrIn = 16'hF000;
   end

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect       (redirect),
      .redirectTarget (redirectTarget),
      .instrIn        (instrIn),
      .instrAddr      (instrAddr),
      .instrOut       (instrOut),
      .pcPlus2Out     (pcPlus2Out),
      .ctrlSignal     (ctrlSignal),
      .validOut       (validOut),
      .halted         (halted)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectTarget = 16'h0000; halt_en = 1'b0;
      #2;
      chk("rst_addr",  instrAddr, 16'h0000);
      chk("rst_instr", instrOut, 16'hE000);
      chk("rst_ctrl",  {8'h00, ctrlSignal}, 16'h00E0);
      chk("rst_pc2",   pcPlus2Out, 16'h0000);
      chk("rst_valid", {15'd0, validOut}, 16'd0);
      chk("rst_halt",  {15'd0, halted}, 16'd0);
      step(); step();
      rst = 1'b0;

      // Sequential fetch from 0
      step();
      chk("seq0_instr", instrOut, 16'h1000);
      chk("seq0_pc2",   pcPlus2Out, 16'h0002);
      chk("seq0_valid", {15'd0, validOut}, 16'd1);
      chk("seq0_ctrl",  {8'h00, ctrlSignal}, 16'h0010);
      chk("seq0_addr",  instrAddr, 16'h0002);
      step();
      chk("seq1_instr", instrOut, 16'h1002);
      chk("seq1_ctrl",  {8'h00, ctrlSignal}, 16'h0012);
      chk("seq1_addr",  instrAddr, 16'h0004);
      step();
      chk("seq2_instr", instrOut, 16'h1004);
      chk("seq2_pc2",   pcPlus2Out, 16'h0006);
      chk("seq2_addr",  instrAddr, 16'h0006);
      step();
      chk("seq3_instr", instrOut, 16'h1006);
      chk("seq3_addr",  instrAddr, 16'h0008);

      // Stall at PC=8 for 3 cycles
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_addr",  instrAddr, 16'h0008);
         chk("stall_instr", instrOut, 16'h1006);
         chk("stall_pc2",   pcPlus2Out, 16'h0008);
         chk("stall_valid", {15'd0, validOut}, 16'd1);
      end
      stall = 1'b0;
      step();
      chk("resume_instr", instrOut, 16'h1008);
      chk("resume_addr",  instrAddr, 16'h000A);
      chk("resume_pc2",   pcPlus2Out, 16'h000A);
      step();
      chk("resume2_instr", instrOut, 16'h100A);
      chk("resume2_addr",  instrAddr, 16'h000C);

      // Redirect with simultaneous stall
      redirect = 1'b1; stall = 1'b1; redirectTarget = 16'h0040;
      step();
      chk("redir_addr",  instrAddr, 16'h0040);
      chk("redir_instr", instrOut, 16'hE000);
      chk("redir_valid", {15'd0, validOut}, 16'd0);
      chk("redir_ctrl",  {8'h00, ctrlSignal}, 16'h00E0);
      redirect = 1'b0; stall = 1'b0;
      step();
      chk("redir_fetch", instrOut, 16'h1040);
      chk("redir_vld1",  {15'd0, validOut}, 16'd1);
      chk("redir_next",  instrAddr, 16'h0042);

      // PC wraparound
      redirect = 1'b1; redirectTarget = 16'hFFFE;
      step();
      chk("wrap_addr0", instrAddr, 16'hFFFE);
      redirect = 1'b0;
      step();
      chk("wrap_addr",  instrAddr, 16'h0000);
      chk("wrap_pc2",   pcPlus2Out, 16'h0000);
      chk("wrap_instr", instrOut, 16'h1FFE);

      // HALT at 0x000C
      halt_en = 1'b1;
      redirect = 1'b1; redirectTarget = 16'h000C;
      step();
      chk("h_pre_addr", instrAddr, 16'h000C);
      redirect = 1'b0;
      step();
      chk("h_instr", instrOut, 16'hF000);
      chk("h_ctrl",  {8'h00, ctrlSignal}, 16'h00F0);
      chk("h_flag",  {15'd0, halted}, 16'd1);
      chk("h_addr",  instrAddr, 16'h000C);
      chk("h_valid", {15'd0, validOut}, 16'd1);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("hold_instr", instrOut, 16'hE000);
         chk("hold_valid", {15'd0, validOut}, 16'd0);
         chk("hold_flag",  {15'd0, halted}, 16'd1);
         chk("hold_addr",  instrAddr, 16'h000C);
      end
      // Redirect out of HALTED
      redirect = 1'b1; redirectTarget = 16'h0020;
      step();
      chk("unh_flag",  {15'd0, halted}, 16'd0);
      chk("unh_addr",  instrAddr, 16'h0020);
      chk("unh_instr", instrOut, 16'hE000);
      redirect = 1'b0;
      step();
      chk("unh_fetch", instrOut, 16'h1020);
      chk("unh_valid", {15'd0, validOut}, 16'd1);
      chk("unh_next",  instrAddr, 16'h0022);

      // HALT fetched under stall waits for the stall to drop
      redirect = 1'b1; redirectTarget = 16'h000C;
      step();
      redirect = 1'b0; stall = 1'b1;
      step();
      chk("hs_flag",  {15'd0, halted}, 16'd0);
      chk("hs_instr", instrOut, 16'hE000);
      chk("hs_addr",  instrAddr, 16'h000C);
      stall = 1'b0;
      step();
      chk("hs_flag2",  {15'd0, halted}, 16'd1);
      chk("hs_instr2", instrOut, 16'hF000);

      // Asynchronous reset between edges while HALTED
      step();
      #2 rst = 1'b1;
      #1;
      chk("ar_addr",  instrAddr, 16'h0000);
      chk("ar_instr", instrOut, 16'hE000);
      chk("ar_ctrl",  {8'h00, ctrlSignal}, 16'h00E0);
      chk("ar_pc2",   pcPlus2Out, 16'h0000);
      chk("ar_valid", {15'd0, validOut}, 16'd0);
      chk("ar_halt",  {15'd0, halted}, 16'd0);
      #1 rst = 1'b0;
      step();
      chk("ar_fetch", instrOut, 16'h1000);
      chk("ar_next",  instrAddr, 16'h0002);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
